add_tree_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point adder tree. Sums N_IN lanes of SIGN_BIT+INT_BIT+FLT_BIT format into one full-precision result.
- Generalises the two-level combinational 3-input adder in two ways: arbitrary input count, and one register stage per tree level with valid/ready flow control.
- Sits in the FFT butterfly datapath, between the twiddle multipliers and the output scaling/rounding stage.

---
 rtl/add_tree_pkg.sv | 19 +
 rtl/add_tree_stage.sv | 44 ++++
 rtl/add_tree_pipe.sv | 82 ++++++++
 tb/tb_add_tree_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_tree_pkg.sv
// add_tree_pkg: shared constants and helpers for the pipelined adder tree
// Exports N_IN_MIN/N_IN_MAX lane limits, SW (helper word width), clog2 and sext.
package add_tree_pkg;
  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 16;
  localparam int SW = 64;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  // Sign-extends the low w bits of x across the SW-bit word; callers keep w+1 bits.
  function automatic logic [SW-1:0] sext(input logic [SW-1:0] x, input int w);
    logic [SW-1:0] m;
    m = {SW{1'b1}} << w;
    return x[w-1] ? (x | m) : (x & ~m);
  endfunction
endpackage

// File: rtl/add_tree_stage.sv
// add_tree_stage: one adder-tree level (pairwise sums, W -> W+1 bits) with its register and valid bit
// Ports: clk, rst_n (async, active low), adv (shift enable), vin/vout (valid in/out),
//        din (N lanes of W bits), dout (registered M=ceil(N/2) lanes of W+1 bits),
//        nxt (combinational value dout loads on the next advance).
module add_tree_stage
  import add_tree_pkg::*;
#(
  parameter int W = 13,
  parameter int N = 4,
  localparam int M = (N + 1) / 2,
  localparam int OW = W + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  logic            vin,
  input  logic [N*W-1:0]  din,
  output logic            vout,
  output logic [M*OW-1:0] dout,
  output logic [M*OW-1:0] nxt
);
  logic [2*M*W-1:0] pad;
  logic [M*OW-1:0] data_d, data_q;
  logic vld_d, vld_q;
  // An odd lane count is padded with a zero lane, so the unpaired value passes through sign-extended.
  always_comb begin
    pad = (2*M*W)'(din);
    nxt = '0;
    for (int i = 0; i < M; i++)
      nxt[i*OW +: OW] = OW'(sext(SW'(pad[2*i*W +: W]), W) + sext(SW'(pad[(2*i+1)*W +: W]), W));
    data_d = adv ? nxt : data_q;
    vld_d = adv ? vin : vld_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      vld_q <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q <= vld_d;
    end
  assign dout = data_q;
  assign vout = vld_q;
endmodule

// File: rtl/add_tree_pipe.sv
// add_tree_pipe: pipelined signed fixed-point adder tree, one register stage per level, valid/ready flow
// Ports: clk, rst_n (async, active low); in_valid/in_ready/din (N_IN packed DW-bit lanes);
//        out_valid/out_ready; dout (OW-bit full sum); dout_sat (DW-bit reduced sum); ovf.
// Macro ADD_TREE_SAT_EN: dout_sat clips to the DW-bit range and ovf flags clipping;
// otherwise dout_sat wraps (low DW bits of dout) and ovf is 0.
module add_tree_pipe
  import add_tree_pkg::*;
#(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT = 6,
  parameter int FLT_BIT = 6,
  parameter int N_IN = 4,
  localparam int DW = SIGN_BIT + INT_BIT + FLT_BIT,
  localparam int LVL = clog2(N_IN),
  localparam int OW = DW + LVL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN*DW-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     dout,
  output logic [DW-1:0]     dout_sat,
  output logic              ovf
);
  logic adv;
  // Whole pipeline moves in lockstep; it stalls only when a result is held at the output.
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("add_tree_pipe: N_IN out of range");
  end
  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int WI = DW + k - 1;
    localparam int NI = (N_IN + (1 << (k - 1)) - 1) >> (k - 1);
    localparam int NO = (NI + 1) / 2;
    logic [NI*WI-1:0] di;
    logic vi;
    logic [NO*(WI+1)-1:0] q, n;
    logic v;
    if (k == 1) begin : g_in
      assign di = din;
      assign vi = in_valid;
    end else begin : g_in
      assign di = g_lvl[k-1].q;
      assign vi = g_lvl[k-1].v;
    end
    add_tree_stage #(.W(WI), .N(NI)) u_stage (
      .clk(clk), .rst_n(rst_n), .adv(adv), .vin(vi), .din(di), .vout(v), .dout(q), .nxt(n)
    );
  end
  assign out_valid = g_lvl[LVL].v;
  assign dout = g_lvl[LVL].q;
`ifdef ADD_TREE_SAT_EN
  localparam logic [OW-1:0] MAX_V = OW'((1 << (DW - 1)) - 1);
  localparam logic [OW-1:0] MIN_V = ~MAX_V;
  logic hi, lo, ovf_d, ovf_q;
  logic [DW-1:0] sat_d, sat_q;
  // Clip is computed from the last level's next value so it registers alongside dout.
  always_comb begin
    hi = $signed(g_lvl[LVL].n) > $signed(MAX_V);
    lo = $signed(g_lvl[LVL].n) < $signed(MIN_V);
    sat_d = !adv ? sat_q : hi ? MAX_V[DW-1:0] : lo ? MIN_V[DW-1:0] : g_lvl[LVL].n[DW-1:0];
    ovf_d = adv ? hi || lo : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  assign dout_sat = sat_q;
  assign ovf = ovf_q && out_valid;
`else
  assign dout_sat = dout[DW-1:0];
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_add_tree_pipe.sv
// tb_add_tree_pipe: self-checking bench for add_tree_pipe (default N_IN=4 plus an N_IN=3 instance)
module tb_add_tree_pipe;
  localparam int DW = 13;
  localparam int OW = 15;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ovf;
  logic [N*DW-1:0] din = '0;
  logic [OW-1:0] dout;
  logic [DW-1:0] dout_sat;
  logic in_valid3 = 1'b0;
  logic in_ready3, out_valid3, ovf3;
  logic [3*DW-1:0] din3 = '0;
  logic [OW-1:0] dout3;
  logic [DW-1:0] dout_sat3;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int mon_s;
  logic stall = 1'b0;
  logic [OW-1:0] hold = '0;
  typedef struct {
    logic [N*DW-1:0] d;
    int s;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  add_tree_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_sat(dout_sat), .ovf(ovf)
  );
  add_tree_pipe #(.N_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .din(din3),
    .out_valid(out_valid3), .out_ready(1'b1), .dout(dout3), .dout_sat(dout_sat3), .ovf(ovf3)
  );

  function automatic logic [N*DW-1:0] pack4(int a, int b, int c, int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic int lane_sum(logic [N*DW-1:0] v);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'($signed(v[i*DW +: DW]));
    return s;
  endfunction

  function automatic logic [DW-1:0] ref_sat(int s);
`ifdef ADD_TREE_SAT_EN
    return s > 4095 ? 13'h0FFF : s < -4096 ? 13'h1000 : DW'(s);
`else
    return DW'(s);
`endif
  endfunction

  function automatic logic ref_ovf(int s);
`ifdef ADD_TREE_SAT_EN
    return s > 4095 || s < -4096;
`else
    return s != s;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_lane();
    int r = $urandom_range(3);
    return r == 0 ? 13'h0FFF : r == 1 ? 13'h1000 : DW'($urandom());
  endfunction

  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(logic [N*DW-1:0] d, int s);
    @(negedge clk);
    in_valid = 1'b1;
    din = d;
    out_ready = 1'b1;
    #1 chk("vec_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("vec_early", out_valid, 0);
    @(negedge clk);
    chk("vec_valid", out_valid, 1);
    chk("vec_dout", $signed(dout), s);
    chk("vec_sat", $signed(dout_sat), $signed(ref_sat(s)));
    chk("vec_ovf", ovf, ref_ovf(s));
    @(negedge clk);
    chk("vec_one_beat", out_valid, 0);
  endtask

  // Scoreboard: transfers in both directions are observed just before the edge that performs them.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_dout", $signed(dout), $signed(hold));
      end
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_s = exp_q.pop_front();
          chk("sb_dout", $signed(dout), mon_s);
          chk("sb_sat", $signed(dout_sat), $signed(ref_sat(mon_s)));
          chk("sb_ovf", ovf, ref_ovf(mon_s));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(lane_sum(din));
      stall = out_valid && !out_ready;
      hold = dout;
    end else stall = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{pack4(100, -50, 7, 1), 58};
    tbl[1] = '{pack4(4095, 4095, 4095, 4095), 16380};
    tbl[2] = '{pack4(-4096, -4096, -4096, -4096), -16384};
    tbl[3] = '{pack4(0, 0, 0, 0), 0};
    tbl[4] = '{pack4(-1, 1, -1, 1), 0};
    tbl[5] = '{pack4(4095, -4096, 4095, -4096), -2};
    tbl[6] = '{pack4(2048, 2048, 0, 0), 4096};
    tbl[7] = '{pack4(-4096, -1, 0, 0), -4097};
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", $signed(dout), 0);
    chk("rst_sat", $signed(dout_sat), 0);
    chk("rst_ovf", ovf, 0);
    #3 rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);
    foreach (tbl[i]) run_vec(tbl[i].d, tbl[i].s);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stream_valid", out_valid, c >= 2);
      if (c >= 2) chk("stream_dout", $signed(dout), 4 * (c - 2));
      in_valid = c < 8;
      din = pack4(c, c, c, c);
      #1 chk("stream_in_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b0;
      din = pack4(10 * (c + 1), 10 * (c + 1), 10 * (c + 1), 10 * (c + 1));
      #1 chk("bp_in_ready", in_ready, c < 2);
      if (c >= 2) chk("bp_dout", $signed(dout), 40);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_rel_valid", out_valid, 1);
    chk("bp_rel_dout0", $signed(dout), 40);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_rel_dout1", $signed(dout), 80);
    @(negedge clk);
    chk("bp_rel_dout2", $signed(dout), 200);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b1;
    din = pack4(300, 300, 300, 300);
    @(negedge clk);
    din = pack4(-7, -7, -7, -7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1 chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_dout", $signed(dout), 0);
    chk("mid_rst_sat", $signed(dout_sat), 0);
    chk("mid_rst_ovf", ovf, 0);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    run_vec(pack4(5, 6, 7, 8), 26);
    @(negedge clk);
    in_valid3 = 1'b1;
    din3 = {DW'(-1), DW'(-1), DW'(-1)};
    @(negedge clk);
    din3 = {DW'(4095), DW'(4095), DW'(4095)};
    chk("n3_early", out_valid3, 0);
    @(negedge clk);
    in_valid3 = 1'b0;
    chk("n3_valid", out_valid3, 1);
    chk("n3_dout", $signed(dout3), -3);
    @(negedge clk);
    chk("n3_dout_max", $signed(dout3), 12285);
    @(negedge clk);
    chk("n3_idle", out_valid3, 0);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      din = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #3 chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
